// File: rtl/shift_pkg.sv
// Shared encodings for the sequential right-shift unit: operation modes and FSM states.
package shift_pkg;

  localparam logic [1:0] MODE_LSR   = 2'b00;
  localparam logic [1:0] MODE_ASR   = 2'b01;
  localparam logic [1:0] MODE_ROR_C = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    FINISH = 2'b10
  } state_t;

endpackage

// File: rtl/rshift_step.sv
// Combinational one-bit right step (logical / arithmetic / rotate-through-carry).
// Rotate is built only when RSHIFT_ROTATE_EN is defined; otherwise mode 10 shifts logically.
module rshift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] data_next,
  output logic             carry_next
);

  always_comb begin
    data_next  = {1'b0, data[WIDTH-1:1]};
    carry_next = data[0];
    case (mode)
      MODE_ASR:   data_next[WIDTH-1] = data[WIDTH-1];
`ifdef RSHIFT_ROTATE_EN
      MODE_ROR_C: data_next[WIDTH-1] = carry;
`endif
      default:    ;
    endcase
  end

`ifndef RSHIFT_ROTATE_EN
  // Carry only feeds the rotate path, which is absent in this build.
  logic unused_carry;
  assign unused_carry = carry;
`endif

endmodule

// File: rtl/rshift_seq_unit.sv
// Sequential right shifter: one bit per clock, count clamped to WIDTH, start/done handshake.
// Define RSHIFT_ROTATE_EN to enable rotate-through-carry for mode 10.
module rshift_seq_unit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] acc_data,
  input  logic [AMT_W-1:0] shift_amt,
  input  logic [1:0]       mode,
  input  logic             ci_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rshift_out,
  output logic             co_rshift,
  output logic             zero
);
  import shift_pkg::*;

  localparam logic [AMT_W-1:0] FULL_CNT = AMT_W'(WIDTH);

  // Handshake: start is taken only in IDLE (operands captured on that edge); done pulses
  // for exactly one cycle, in FINISH, with rshift_out/co_rshift/zero already valid.
  state_t           state;
  logic [WIDTH-1:0] work;
  logic             work_c;
  logic [1:0]       op_mode;
  logic [AMT_W-1:0] count;
  logic [AMT_W-1:0] load_cnt;
  logic [WIDTH-1:0] step_data;
  logic             step_c;

  assign load_cnt = (shift_amt > FULL_CNT) ? FULL_CNT : shift_amt;

  rshift_step #(.WIDTH(WIDTH)) u_step (
    .data       (work),
    .carry      (work_c),
    .mode       (op_mode),
    .data_next  (step_data),
    .carry_next (step_c)
  );

  // Results are registered on the edge entering FINISH so they are valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      work       <= '0;
      work_c     <= 1'b0;
      op_mode    <= MODE_LSR;
      count      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rshift_out <= '0;
      co_rshift  <= 1'b0;
      zero       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            work    <= acc_data;
            work_c  <= ci_in;
            op_mode <= mode;
            count   <= load_cnt;
            busy    <= 1'b1;
            if (load_cnt == '0) begin
              rshift_out <= acc_data;
              co_rshift  <= ci_in;
              zero       <= (acc_data == '0);
              done       <= 1'b1;
              state      <= FINISH;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work   <= step_data;
          work_c <= step_c;
          count  <= count - AMT_W'(1);
          if (count == AMT_W'(1)) begin
            rshift_out <= step_data;
            co_rshift  <= step_c;
            zero       <= (step_data == '0);
            done       <= 1'b1;
            state      <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rshift_seq_unit.sv
// Bench for rshift_seq_unit (WIDTH=8): directed literal cases plus random ops against a shift model.
module tb_rshift_seq_unit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] acc_data;
  logic [3:0] shift_amt;
  logic [1:0] mode;
  logic       ci_in;
  logic       busy;
  logic       done;
  logic [7:0] rshift_out;
  logic       co_rshift;
  logic       zero;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [9:0] exp_q[$];
  logic [7:0] hold_out;
  logic       hold_co;
  logic       hold_zero;

  rshift_seq_unit #(.WIDTH(8), .AMT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .acc_data   (acc_data),
    .shift_amt  (shift_amt),
    .mode       (mode),
    .ci_in      (ci_in),
    .busy       (busy),
    .done       (done),
    .rshift_out (rshift_out),
    .co_rshift  (co_rshift),
    .zero       (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-shift arithmetic on the operand; result packed as {zero, carry, data}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [3:0] amt,
                                       input logic [1:0] m, input logic c);
    int n;
    logic [7:0] r;
    logic       co;
    logic [8:0] ring;
    n = (amt > 4'd8) ? 8 : int'(amt);
    if (n == 0) begin
      r  = a;
      co = c;
    end else begin
      if (m == 2'b01) r = 8'($signed(a) >>> n);
      else            r = a >> n;
      co = a[n-1];
`ifdef RSHIFT_ROTATE_EN
      if (m == 2'b10) begin
        ring = {c, a};
        ring = (ring >> n) | (ring << (9 - n));
        r    = ring[7:0];
        co   = ring[8];
      end
`endif
    end
    ring = '0;
    return {(r == 8'h00), co, r};
  endfunction

  // scoreboard: every negedge, done pops an expectation, otherwise outputs must hold
  always @(negedge clk) begin
    if (chk_en) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          check("spurious_done", 32'(done), 32'd0);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          check("result_data", 32'(rshift_out), 32'(e[7:0]));
          check("result_carry", 32'(co_rshift), 32'(e[8]));
          check("result_zero", 32'(zero), 32'(e[9]));
          hold_out  = e[7:0];
          hold_co   = e[8];
          hold_zero = e[9];
        end
      end else begin
        check("hold_data", 32'(rshift_out), 32'(hold_out));
        check("hold_carry", 32'(co_rshift), 32'(hold_co));
        check("hold_zero", 32'(zero), 32'(hold_zero));
      end
    end
  end

  // driver: returns in the done cycle (or after timeout); poke_at pulses start while busy
  task automatic run_op(input logic [7:0] a, input logic [3:0] amt, input logic [1:0] m,
                        input logic c, input int poke_at, input bit hold_done);
    int cycles;
    int n;
    n = (amt > 4'd8) ? 8 : int'(amt);
    @(posedge clk); #1;
    acc_data = a; shift_amt = amt; mode = m; ci_in = c; start = 1'b1;
    exp_q.push_back(model(a, amt, m, c));
    @(posedge clk); #1;
    start = 1'b0;
    acc_data = 8'($urandom); shift_amt = 4'($urandom); mode = 2'($urandom); ci_in = 1'($urandom);
    cycles = 1;
    check("busy_after_accept", 32'(busy), 32'd1);
    while (!done && cycles < 40) begin
      start = (cycles == poke_at);
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'(done), 32'd1);
    check("latency", 32'(cycles), 32'(n + 1));
    if (hold_done) begin
      acc_data = 8'h00; shift_amt = 4'd0; ci_in = 1'b1; start = 1'b1;
    end
  endtask

  initial begin
    int extra;
    logic [9:0] pin;
    rst = 1'b1; start = 1'b0; acc_data = '0; shift_amt = '0; mode = '0; ci_in = 1'b0;
    hold_out = '0; hold_co = 1'b0; hold_zero = 1'b0;

    // pin the model with hand-computed values
    pin = model(8'hB5, 4'd3, 2'b00, 1'b0);  check("model_lsr_b5", 32'(pin), 32'h116);
    pin = model(8'h90, 4'd2, 2'b01, 1'b0);  check("model_asr_90", 32'(pin), 32'h0E4);
    pin = model(8'h90, 4'd2, 2'b00, 1'b0);  check("model_lsr_90", 32'(pin), 32'h024);
    pin = model(8'hFF, 4'd15, 2'b00, 1'b0); check("model_clamp", 32'(pin), 32'h300);
    pin = model(8'h3C, 4'd0, 2'b00, 1'b1);  check("model_zero_cnt", 32'(pin), 32'h13C);
`ifdef RSHIFT_ROTATE_EN
    pin = model(8'h01, 4'd1, 2'b10, 1'b1);  check("model_ror", 32'(pin), 32'h180);
`else
    pin = model(8'h01, 4'd1, 2'b10, 1'b1);  check("model_ror_off", 32'(pin), 32'h300);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(rshift_out), 32'd0);
    check("rst_co", 32'(co_rshift), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;

    run_op(8'hB5, 4'd3, 2'b00, 1'b0, 0, 0);
    check("lsr_b5_out", 32'(rshift_out), 32'h16);
    check("lsr_b5_co", 32'(co_rshift), 32'd1);
    check("lsr_b5_zero", 32'(zero), 32'd0);

    run_op(8'h90, 4'd2, 2'b01, 1'b0, 0, 0);
    check("asr_90_out", 32'(rshift_out), 32'hE4);
    check("asr_90_co", 32'(co_rshift), 32'd0);
    run_op(8'h90, 4'd2, 2'b00, 1'b0, 0, 0);
    check("lsr_90_out", 32'(rshift_out), 32'h24);

    run_op(8'h01, 4'd1, 2'b10, 1'b1, 0, 0);
`ifdef RSHIFT_ROTATE_EN
    check("ror_out", 32'(rshift_out), 32'h80);
    check("ror_co", 32'(co_rshift), 32'd1);
`else
    check("ror_off_out", 32'(rshift_out), 32'h00);
    check("ror_off_co", 32'(co_rshift), 32'd1);
    check("ror_off_zero", 32'(zero), 32'd1);
`endif

    run_op(8'h3C, 4'd0, 2'b00, 1'b1, 0, 0);
    check("zcnt_out", 32'(rshift_out), 32'h3C);
    check("zcnt_co", 32'(co_rshift), 32'd1);

    run_op(8'hFF, 4'd15, 2'b00, 1'b0, 0, 0);
    check("clamp_out", 32'(rshift_out), 32'h00);
    check("clamp_co", 32'(co_rshift), 32'd1);
    check("clamp_zero", 32'(zero), 32'd1);

    // start pulsed while busy, then start held through the done cycle
    run_op(8'hC3, 4'd6, 2'b01, 1'b0, 3, 1);
    check("poke_out", 32'(rshift_out), 32'hFF);
    @(posedge clk); #1;
    start = 1'b0;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("no_extra_done", 32'(extra), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // reset in the middle of a shift
    @(posedge clk); #1;
    acc_data = 8'hAA; shift_amt = 4'd6; mode = 2'b00; ci_in = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'hAA, 4'd6, 2'b00, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    hold_out = '0; hold_co = 1'b0; hold_zero = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_out", 32'(rshift_out), 32'd0);
    check("midrst_co", 32'(co_rshift), 32'd0);
    check("midrst_zero", 32'(zero), 32'd0);
    run_op(8'h81, 4'd4, 2'b01, 1'b0, 0, 0);
    check("after_rst_out", 32'(rshift_out), 32'hF8);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      run_op(8'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom), (i % 5 == 0) ? 2 : 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rshift_seq_unit.md
Name: rshift_seq_unit

Overview:
- Sequential right-shift unit for the generalized processor's accumulator datapath; the right-direction counterpart of the single-cycle left shifter.
- Shifts the accumulator right by a programmable count, one bit per clock, under a start/done handshake.
- Supports logical, arithmetic and (optionally) rotate-through-carry modes.
- Returns the shifted data, the last bit shifted out as carry, and a zero flag to the ALU/flag logic.

Parameters:
- WIDTH, 8, accumulator data width in bits (16 for the wide build).
- AMT_W, 4, width of shift_amt; must be ≥ $clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- acc_data  input  WIDTH  operand, captured when start is accepted.
- shift_amt  input  AMT_W  shift count, captured with start.
- mode  input  2  00 logical, 01 arithmetic, 10 rotate-through-carry, 11 reserved (treated as logical).
- ci_in  input  1  carry-in, captured with start; used by rotate mode and as the carry result for zero-count shifts.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse when the result is valid.
- rshift_out  output  WIDTH  result register.
- co_rshift  output  1  last bit shifted out of bit 0.
- zero  output  1  high when rshift_out == 0; updated with done.

Behaviour:
- Reset (rst=1 at a clock edge): state goes to IDLE. busy=0, done=0, rshift_out=0, co_rshift=0, zero=0.
  - Reset overrides everything, including an operation in progress. No partial result is published.
- States: IDLE, SHIFT, FINISH.
- IDLE:
  - If start=1, capture acc_data, ci_in and mode.
  - Load the count as min(shift_amt, WIDTH).
  - Go to SHIFT if the count > 0, otherwise go to FINISH.
- SHIFT: each cycle performs one 1-bit step and decrements the count. Go to FINISH when the count reaches 0 after the step.
  - Logical step: {0, d[W-1:1]}, carry = d[0].
  - Arithmetic step: {d[W-1], d[W-1:1]}, carry = d[0].
  - Rotate step: {c, d[W-1:1]}, c_next = d[0].
- FINISH:
  - Write the working register to rshift_out and the carry to co_rshift.
  - Compute zero from the written value.
  - Pulse done=1 for this one cycle, then return to IDLE.
- busy is 1 in SHIFT and FINISH.
- Latency: with count n (after clamping), done is high n+1 cycles after the start edge. For n=0, done is high on the next cycle, rshift_out = acc_data and co_rshift = ci_in.
- Clamp: counts above WIDTH are executed as WIDTH.
- Busy handling: start is ignored while busy; no queueing. Operands are captured, so input changes after acceptance have no effect.
- A start asserted in the same cycle that done pulses is ignored, because the FSM is in FINISH. A new start is accepted in the following IDLE cycle.
- Outputs hold their values until the next FINISH or rst.

Optional Feature:
- RSHIFT_ROTATE_EN defined: mode 10 performs rotate-through-carry as described.
- Not defined: mode 10 decodes as logical. The rotate datapath and carry feedback are not synthesized.

Decomposition:
- Shared package shift_pkg holds:
  - the mode encodings (MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_ROR_C=2'b10);
  - the FSM state typedef (IDLE/SHIFT/FINISH).
- One natural sub-module: rshift_step, a combinational single-bit shifter (data, carry, mode → data', carry'), instantiated once in the SHIFT datapath.

Test Plan:
- WIDTH=8, logical, acc=8'hB5, amt=3 → done at cycle 4; rshift_out=8'h16, co_rshift=1, zero=0.
- Arithmetic, acc=8'h90, amt=2 → rshift_out=8'hE4, co_rshift=0. Same operand with logical → rshift_out=8'h24.
- Rotate (RSHIFT_ROTATE_EN set), acc=8'h01, ci_in=1, amt=1 → rshift_out=8'h80, co_rshift=1. With the macro undefined, the same stimulus → rshift_out=8'h00, co_rshift=1, zero=1.
- amt=0, acc=8'h3C, ci_in=1 → done next cycle; rshift_out=8'h3C, co_rshift=1. amt=15 logical, acc=8'hFF → clamped to 8; rshift_out=8'h00, co_rshift=1, zero=1, done at cycle 9.
- Second start pulsed while busy, and start held during the done cycle → both ignored; exactly one done per accepted start.
- rst asserted mid-SHIFT → next cycle busy=0, done=0, all outputs 0; a fresh start then completes normally.
